regfile_port_arbiter: RTL and testbench

Arbiter and sequencer for the 8x8 register file's single write port and A-read port. It shares the port between the core writeback/operand path (requester 0) and the debug port (requester 1). It also sequences a multi-cycle CLEAR that zeroes R1..R7, giving the design a hardware register wipe. The block sits between the core/debug logic and the register file and drives AA, BA, DA, DataIn and WR.

---
 rtl/regfile_port_arbiter_pkg.sv | 19 +
 rtl/regfile_port_arbiter_if.sv | 40 ++++
 rtl/regfile_port_arbiter_starve_ctr.sv | 35 +++
 rtl/regfile_port_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and default sizes for the register-file port arbiter.
package regfile_ctrl_pkg;
  localparam int RF_DATA_W     = 8;
  localparam int RF_ADDR_W     = 3;
  localparam int RF_STARVE_MAX = 4;
  localparam int REG_COUNT     = 2 ** RF_ADDR_W;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_RSVD  = 2'b11
  } dbg_cmd_e;
endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Core and debug requester bundle; requesters use master, the arbiter uses slave.
interface regfile_port_arbiter_if
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_da;
  logic [ADDR_W-1:0] core_aa;
  logic [ADDR_W-1:0] core_ba;
  logic [DATA_W-1:0] core_din;
  logic              core_gnt;
  logic [DATA_W-1:0] core_rdata_a;
  logic [DATA_W-1:0] core_rdata_b;

  logic              dbg_req;
  logic [1:0]        dbg_cmd;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_din;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;
  logic              busy;

  modport master (
    output core_req, core_we, core_da, core_aa, core_ba, core_din,
    output dbg_req, dbg_cmd, dbg_addr, dbg_din,
    input  core_gnt, core_rdata_a, core_rdata_b,
    input  dbg_gnt, dbg_rdata, dbg_rvalid, busy
  );

  modport slave (
    input  core_req, core_we, core_da, core_aa, core_ba, core_din,
    input  dbg_req, dbg_cmd, dbg_addr, dbg_din,
    output core_gnt, core_rdata_a, core_rdata_b,
    output dbg_gnt, dbg_rdata, dbg_rvalid, busy
  );
endinterface

// File: rtl/regfile_port_arbiter_starve_ctr.sv
// Saturating count of core grants taken while debug waits; sat_o means debug must win next.
// Single-cycle update, clear has priority over increment.
module regfile_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);
  localparam int            CW    = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX_C);
endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file write/A-read port between core and debug, and runs the R1..R(N-1) wipe.
// Grants are combinational (zero latency); debug read data lands one cycle after its handshake.
module regfile_port_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int STARVE_MAX = RF_STARVE_MAX
) (
  input  logic                  Clk,
  input  logic                  Reset,
  regfile_port_arbiter_if.slave req,
  output logic [ADDR_W-1:0]     AA,
  output logic [ADDR_W-1:0]     BA,
  output logic [ADDR_W-1:0]     DA,
  output logic [DATA_W-1:0]     DataIn,
  output logic                  WR,
  input  logic [DATA_W-1:0]     DataA,
  input  logic [DATA_W-1:0]     DataB
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((2 ** ADDR_W) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic core_gnt, dbg_gnt;
  logic core_hs, dbg_hs;
  logic starve_sat, starve;

  assign starve  = req.dbg_req && starve_sat;
  assign core_hs = req.core_req && core_gnt;
  assign dbg_hs  = req.dbg_req && dbg_gnt;

  regfile_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk_i (Clk),
    .rst_i (Reset),
    .inc_i (core_hs && req.dbg_req),
    .clr_i (dbg_hs || !req.dbg_req),
    .sat_o (starve_sat)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rvalid_d  = dbg_hs && (req.dbg_cmd == CMD_READ);
    rdata_d   = rvalid_d ? DataA : rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (dbg_hs && (req.dbg_cmd == CMD_CLEAR)) begin
          state_d   = ST_CLEAR;
          clr_idx_d = ADDR_W'(1);
        end
      end
      ST_CLEAR: begin
        // Index wraps to 0 on the final edge, leaving it ready for the next wipe.
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    AA       = req.core_aa;
    BA       = req.core_ba;
    DA       = req.core_da;
    DataIn   = req.core_din;
    WR       = 1'b0;
    if (state_q == ST_CLEAR) begin
      DA     = clr_idx_q;
      DataIn = '0;
      WR     = 1'b1;
    end else begin
      core_gnt = req.core_req && !starve;
      dbg_gnt  = req.dbg_req && !core_gnt;
      if (core_gnt) begin
        WR = req.core_we;
      end else if (dbg_gnt) begin
        AA     = req.dbg_addr;
        DA     = req.dbg_addr;
        DataIn = req.dbg_din;
        WR     = (req.dbg_cmd == CMD_WRITE);
      end
    end
    // Reset also kills the port immediately, before the async state reset settles anything.
    if (Reset) begin
      core_gnt = 1'b0;
      dbg_gnt  = 1'b0;
      WR       = 1'b0;
    end
  end

  assign req.core_gnt     = core_gnt;
  assign req.dbg_gnt      = dbg_gnt;
  assign req.core_rdata_a = DataA;
  assign req.core_rdata_b = DataB;
  assign req.dbg_rdata    = rdata_q;
  assign req.dbg_rvalid   = rvalid_q;
  assign req.busy         = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: negedge-write register file plus a cycle-level reference model.
module tb_regfile_port_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int SMAX = 4;
  localparam int NREG = REG_COUNT;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  regfile_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  logic [AW-1:0] AA, BA, DA;
  logic [DW-1:0] DataIn, DataA, DataB;
  logic          WR;

  regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .req    (bus),
    .AA     (AA),
    .BA     (BA),
    .DA     (DA),
    .DataIn (DataIn),
    .WR     (WR),
    .DataA  (DataA),
    .DataB  (DataB)
  );

  // Register file: combinational read, negedge write, R0 hard-wired to zero.
  logic [DW-1:0] rf [NREG];
  logic          rf_init;
  assign DataA = rf[AA];
  assign DataB = rf[BA];
  always @(negedge Clk) begin
    if (rf_init) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (WR && (DA != 0)) begin
      rf[DA] <= DataIn;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] m_rf [NREG];
  int            m_starve;
  int            m_clr_left;
  int            m_clr_addr;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;
  logic          e_cg, e_dg;
  logic          obs_cg, obs_dg, obs_busy;

  task automatic model_reset();
    m_starve   = 0;
    m_clr_left = 0;
    m_clr_addr = 0;
    m_rvalid   = 1'b0;
    m_rdata    = '0;
    e_cg       = 1'b0;
    e_dg       = 1'b0;
  endtask

  task automatic set_core(input logic rq, input logic we, input logic [AW-1:0] da,
                          input logic [AW-1:0] aa, input logic [AW-1:0] ba, input logic [DW-1:0] din);
    bus.core_req = rq; bus.core_we = we; bus.core_da = da;
    bus.core_aa  = aa; bus.core_ba = ba; bus.core_din = din;
  endtask

  task automatic set_dbg(input logic rq, input logic [1:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din);
    bus.dbg_req = rq; bus.dbg_cmd = cmd; bus.dbg_addr = addr; bus.dbg_din = din;
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle();
    logic starving;
    logic rv_next;
    #2;
    obs_cg   = bus.core_gnt;
    obs_dg   = bus.dbg_gnt;
    obs_busy = bus.busy;
    if (m_clr_left > 0) begin
      e_cg = 1'b0;
      e_dg = 1'b0;
      check("clr_busy", bus.busy, 1);
      check("clr_wr", WR, 1);
      check("clr_da", DA, m_clr_addr);
      check("clr_din", DataIn, 0);
    end else begin
      starving = bus.dbg_req && (m_starve >= SMAX);
      e_cg = bus.core_req && !starving;
      e_dg = bus.dbg_req && !e_cg;
      check("idle_busy", bus.busy, 0);
      if (e_cg) begin
        check("core_wr", WR, bus.core_we);
        check("core_aa", AA, bus.core_aa);
        check("core_dataa", bus.core_rdata_a, m_rf[bus.core_aa]);
        check("core_datab", bus.core_rdata_b, m_rf[bus.core_ba]);
        if (bus.core_we) begin
          check("core_da", DA, bus.core_da);
          check("core_din", DataIn, bus.core_din);
        end
      end else if (e_dg) begin
        check("dbg_wr", WR, bus.dbg_cmd == CMD_WRITE);
        check("dbg_aa", AA, bus.dbg_addr);
        if (bus.dbg_cmd == CMD_WRITE) begin
          check("dbg_da", DA, bus.dbg_addr);
          check("dbg_din", DataIn, bus.dbg_din);
        end
      end else begin
        check("nogrant_wr", WR, 0);
      end
    end
    check("core_gnt", obs_cg, e_cg);
    check("dbg_gnt", obs_dg, e_dg);

    @(posedge Clk);
    #1;
    rv_next = 1'b0;
    if (m_clr_left > 0) begin
      m_rf[m_clr_addr] = '0;
      m_clr_addr++;
      m_clr_left--;
    end else if (e_cg) begin
      if (bus.core_we && (bus.core_da != 0)) m_rf[bus.core_da] = bus.core_din;
      if (bus.dbg_req && (m_starve < SMAX)) m_starve++;
    end else if (e_dg) begin
      case (bus.dbg_cmd)
        CMD_READ: begin
          m_rdata = m_rf[bus.dbg_addr];
          rv_next = 1'b1;
        end
        CMD_WRITE: if (bus.dbg_addr != 0) m_rf[bus.dbg_addr] = bus.dbg_din;
        CMD_CLEAR: begin
          m_clr_left = NREG - 1;
          m_clr_addr = 1;
        end
        default: ;
      endcase
    end
    if (!bus.dbg_req || e_dg) m_starve = 0;
    m_rvalid = rv_next;
    check("rvalid", bus.dbg_rvalid, m_rvalid);
    check("rdata", bus.dbg_rdata, m_rdata);
  endtask

  task automatic preload_ff();
    for (int r = 1; r < NREG; r++) begin
      set_core(1'b1, 1'b1, AW'(r), '0, '0, 8'hFF);
      cycle();
    end
    set_core(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    int n_core;
    int n_busy;
    logic got_dg;

    Reset   = 1'b1;
    rf_init = 1'b1;
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    model_reset();
    set_core(1'b1, 1'b1, 3'd3, '0, '0, 8'hAA);
    set_dbg(1'b1, CMD_WRITE, 3'd1, 8'h11);
    @(posedge Clk);
    #1;
    check("rst_core_gnt", bus.core_gnt, 0);
    check("rst_dbg_gnt", bus.dbg_gnt, 0);
    check("rst_wr", WR, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rvalid", bus.dbg_rvalid, 0);
    check("rst_rdata", bus.dbg_rdata, 0);
    @(posedge Clk);
    #1;
    rf_init = 1'b0;
    Reset   = 1'b0;
    set_dbg(1'b0, CMD_READ, '0, '0);

    // Core write R3, read it back, then idle
    set_core(1'b1, 1'b1, 3'd3, '0, '0, 8'h5A); cycle();
    set_core(1'b1, 1'b0, '0, 3'd3, 3'd3, '0);  cycle();
    check("t1_rf3", rf[3], 8'h5A);
    set_core(1'b0, 1'b0, '0, '0, '0, '0);      cycle();

    // Debug read of core-written R2; debug write to R0 is harmless
    set_core(1'b1, 1'b1, 3'd2, '0, '0, 8'h02); cycle();
    set_core(1'b0, 1'b0, '0, '0, '0, '0);
    set_dbg(1'b1, CMD_READ, 3'd2, '0);         cycle();
    check("t2_rvalid", bus.dbg_rvalid, 1);
    check("t2_rdata", bus.dbg_rdata, 8'h02);
    set_dbg(1'b0, CMD_READ, '0, '0);           cycle();
    set_dbg(1'b1, CMD_WRITE, 3'd0, 8'h77);     cycle();
    set_dbg(1'b1, CMD_READ, 3'd0, '0);         cycle();
    check("t2_r0_rdata", bus.dbg_rdata, 8'h00);
    set_dbg(1'b1, CMD_RSVD, 3'd4, 8'h99);      cycle();
    set_dbg(1'b0, CMD_READ, '0, '0);           cycle();

    // Starvation bound with a continuous core stream
    set_core(1'b1, 1'b1, 3'd4, 3'd1, 3'd2, 8'h40);
    set_dbg(1'b1, CMD_WRITE, 3'd6, 8'h66);
    n_core = 0;
    got_dg = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_cg) n_core++;
      if (obs_dg) begin
        got_dg = 1'b1;
        break;
      end
    end
    set_dbg(1'b0, CMD_READ, '0, '0);
    check("starve_core_grants", n_core, SMAX);
    check("starve_dbg_gnt", got_dg, 1);
    cycle();
    check("core_resume", obs_cg, 1);
    set_core(1'b0, 1'b0, '0, '0, '0, '0);

    // Full CLEAR with core stalled behind it
    preload_ff();
    set_dbg(1'b1, CMD_CLEAR, '0, '0); cycle();
    set_dbg(1'b0, CMD_READ, '0, '0);
    set_core(1'b1, 1'b0, '0, 3'd1, 3'd7, '0);
    n_busy = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_busy) n_busy++;
    end
    check("clear_busy_cycles", n_busy, NREG - 1);
    for (int r = 0; r < NREG; r++) check("clear_rf_zero", rf[r], 0);
    set_core(1'b0, 1'b0, '0, '0, '0, '0);

    // Reset on the third CLEAR cycle
    preload_ff();
    set_dbg(1'b1, CMD_CLEAR, '0, '0); cycle();
    set_dbg(1'b0, CMD_READ, '0, '0);
    cycle();
    cycle();
    set_core(1'b1, 1'b0, '0, '0, '0, '0);
    set_dbg(1'b1, CMD_READ, 3'd5, '0);
    Reset = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_wr", WR, 0);
    check("abort_core_gnt", bus.core_gnt, 0);
    check("abort_dbg_gnt", bus.dbg_gnt, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    set_core(1'b0, 1'b0, '0, '0, '0, '0);
    set_dbg(1'b0, CMD_READ, '0, '0);
    check("abort_rvalid", bus.dbg_rvalid, 0);
    check("abort_rdata", bus.dbg_rdata, 0);
    check("abort_r2", rf[2], 8'h00);
    check("abort_r3", rf[3], 8'hFF);
    for (int r = 0; r < NREG; r++) check("abort_rf", rf[r], m_rf[r]);
    cycle();

    // Simultaneous writes to R5: core first, debug next
    set_core(1'b1, 1'b1, 3'd5, '0, '0, 8'h11);
    set_dbg(1'b1, CMD_WRITE, 3'd5, 8'h22);
    cycle();
    check("sim_core_first", rf[5], 8'h11);
    set_core(1'b0, 1'b0, '0, '0, '0, '0);
    cycle();
    check("sim_dbg_second", rf[5], 8'h22);
    set_dbg(1'b0, CMD_READ, '0, '0);
    cycle();

    // Randomized traffic, requests held until their handshake
    for (int n = 0; n < 400; n++) begin
      if (!bus.core_req || e_cg) begin
        set_core($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      end
      if (!bus.dbg_req || e_dg) begin
        int c;
        logic [1:0] cmd;
        c = $urandom_range(0, 15);
        cmd = (c == 0) ? CMD_CLEAR : (c == 1) ? CMD_RSVD : (c < 9) ? CMD_READ : CMD_WRITE;
        set_dbg($urandom_range(0, 2) == 0, cmd, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      end
      cycle();
    end
    for (int r = 0; r < NREG; r++) check("rand_rf_final", rf[r], m_rf[r]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
